// File: rtl/regfile_write_arbiter_if.sv
// Write-request bundle between two requesters, the arbiter and the register file.
// The slave modport is the arbiter's view; master is the requester/regfile side.
interface regfile_write_arbiter_if #(
  parameter int num_bit_of_data   = 32,
  parameter int num_bit_of_column = 2
);
  logic                         Req0_Valid;
  logic [num_bit_of_column-1:0] Req0_Addr;
  logic [num_bit_of_data-1:0]   Req0_Data;
  logic                         Req0_Ready;
  logic                         Req1_Valid;
  logic [num_bit_of_column-1:0] Req1_Addr;
  logic [num_bit_of_data-1:0]   Req1_Data;
  logic                         Req1_Ready;
  logic                         WE;
  logic [num_bit_of_column-1:0] In_Addr;
  logic [num_bit_of_data-1:0]   Data_in;
  logic                         Grant_Id;
  logic [7:0]                   Wr_Count0;
  logic [7:0]                   Wr_Count1;

  modport master (
    output Req0_Valid, Req0_Addr, Req0_Data, Req1_Valid, Req1_Addr, Req1_Data,
    input  Req0_Ready, Req1_Ready, WE, In_Addr, Data_in, Grant_Id, Wr_Count0, Wr_Count1
  );

  modport slave (
    input  Req0_Valid, Req0_Addr, Req0_Data, Req1_Valid, Req1_Addr, Req1_Data,
    output Req0_Ready, Req1_Ready, WE, In_Addr, Data_in, Grant_Id, Wr_Count0, Wr_Count1
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter merging two register-file write requesters onto one
// write port, with a one-cycle registered write path and per-requester counters.
module regfile_write_arbiter #(
  parameter int num_bit_of_data   = 32,
  parameter int num_bit_of_column = 2
) (
  input logic                   CLK,
  input logic                   RST,
  regfile_write_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR0  = 2'd1,
    WR1  = 2'd2
  } state_t;

  state_t                       state;
  state_t                       state_next;
  logic                         prio;
  logic                         grant0;
  logic                         grant1;
  logic [num_bit_of_column-1:0] addr_q;
  logic [num_bit_of_data-1:0]   data_q;
  logic [7:0]                   count0;
  logic [7:0]                   count1;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
    grant0     = 1'b0;
    grant1     = 1'b0;
    state_next = IDLE;
    bus.WE       = (state != IDLE);
    bus.Grant_Id = (state == WR1);

    // Prio only matters when both requesters contend.
    if (!RST) begin
      if (bus.Req0_Valid && (!bus.Req1_Valid || !prio)) grant0 = 1'b1;
      else if (bus.Req1_Valid)                          grant1 = 1'b1;
    end

    if (grant0)      state_next = WR0;
    else if (grant1) state_next = WR1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      prio   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      count0 <= 8'd0;
      count1 <= 8'd0;
    end else if (grant0) begin
      prio   <= 1'b1;
      addr_q <= bus.Req0_Addr;
      data_q <= bus.Req0_Data;
      count0 <= count0 + 8'd1;
    end else if (grant1) begin
      prio   <= 1'b0;
      addr_q <= bus.Req1_Addr;
      data_q <= bus.Req1_Data;
      count1 <= count1 + 8'd1;
    end
  end

  assign bus.Req0_Ready = grant0;
  assign bus.Req1_Ready = grant1;
  assign bus.In_Addr    = addr_q;
  assign bus.Data_in    = data_q;
  assign bus.Wr_Count0  = count0;
  assign bus.Wr_Count1  = count1;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a behavioural register file
// that commits WE/In_Addr/Data_in on each rising edge.
module tb_regfile_write_arbiter;

  logic CLK;
  logic RST;
  int   n_assert;
  int   n_fail;

  logic [31:0] rf_model [4];

  regfile_write_arbiter_if #(.num_bit_of_data(32), .num_bit_of_column(2)) bus ();

  regfile_write_arbiter #(
    .num_bit_of_data  (32),
    .num_bit_of_column(2)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (bus.WE) rf_model[bus.In_Addr] <= bus.Data_in;
  end

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_assert++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance past a rising edge; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    n_assert        = 0;
    n_fail          = 0;
    RST             = 1'b1;
    bus.Req0_Valid  = 1'b0;
    bus.Req0_Addr   = 2'd0;
    bus.Req0_Data   = 32'd0;
    bus.Req1_Valid  = 1'b0;
    bus.Req1_Addr   = 2'd0;
    bus.Req1_Data   = 32'd0;
    tick();
    tick();

    // Reset state
    check("rst_we",     bus.WE,        1'b0);
    check("rst_addr",   bus.In_Addr,   2'd0);
    check("rst_data",   bus.Data_in,   32'd0);
    check("rst_gid",    bus.Grant_Id,  1'b0);
    check("rst_cnt0",   bus.Wr_Count0, 8'd0);
    check("rst_cnt1",   bus.Wr_Count1, 8'd0);

    // Single request from requester 0
    RST            = 1'b0;
    bus.Req0_Valid = 1'b1;
    bus.Req0_Addr  = 2'd2;
    bus.Req0_Data  = 32'hDEADBEEF;
    settle();
    check("single_rdy0", bus.Req0_Ready, 1'b1);
    check("single_rdy1", bus.Req1_Ready, 1'b0);
    tick();
    bus.Req0_Valid = 1'b0;
    settle();
    check("single_we",   bus.WE,        1'b1);
    check("single_addr", bus.In_Addr,   2'd2);
    check("single_data", bus.Data_in,   32'hDEADBEEF);
    check("single_gid",  bus.Grant_Id,  1'b0);
    check("single_cnt0", bus.Wr_Count0, 8'd1);
    tick();
    check("single_idle_we",   bus.WE,      1'b0);
    check("single_idle_addr", bus.In_Addr, 2'd2);
    check("single_idle_data", bus.Data_in, 32'hDEADBEEF);

    // Contention: both valid for 4 cycles after reset -> 0,1,0,1
    RST = 1'b1;
    tick();
    RST            = 1'b0;
    bus.Req0_Valid = 1'b1;
    bus.Req0_Addr  = 2'd0;
    bus.Req0_Data  = 32'h000000A0;
    bus.Req1_Valid = 1'b1;
    bus.Req1_Addr  = 2'd3;
    bus.Req1_Data  = 32'h000000B1;
    settle();
    check("cont_c1_rdy0", bus.Req0_Ready, 1'b1);
    check("cont_c1_rdy1", bus.Req1_Ready, 1'b0);
    tick();
    check("cont_c2_rdy1", bus.Req1_Ready, 1'b1);
    check("cont_w1_we",   bus.WE,         1'b1);
    check("cont_w1_gid",  bus.Grant_Id,   1'b0);
    check("cont_w1_data", bus.Data_in,    32'h000000A0);
    tick();
    check("cont_c3_rdy0", bus.Req0_Ready, 1'b1);
    check("cont_w2_we",   bus.WE,         1'b1);
    check("cont_w2_gid",  bus.Grant_Id,   1'b1);
    check("cont_w2_addr", bus.In_Addr,    2'd3);
    tick();
    check("cont_c4_rdy1", bus.Req1_Ready, 1'b1);
    check("cont_w3_we",   bus.WE,         1'b1);
    check("cont_w3_gid",  bus.Grant_Id,   1'b0);
    tick();
    bus.Req0_Valid = 1'b0;
    bus.Req1_Valid = 1'b0;
    settle();
    check("cont_w4_we",   bus.WE,        1'b1);
    check("cont_w4_gid",  bus.Grant_Id,  1'b1);
    check("cont_cnt0",    bus.Wr_Count0, 8'd2);
    check("cont_cnt1",    bus.Wr_Count1, 8'd2);
    tick();
    check("cont_end_we",  bus.WE,        1'b0);

    // Same-address collision with Prio=1 (a lone requester-0 write sets it)
    bus.Req0_Valid = 1'b1;
    bus.Req0_Addr  = 2'd0;
    bus.Req0_Data  = 32'h55;
    tick();
    bus.Req0_Valid = 1'b1;
    bus.Req0_Addr  = 2'd1;
    bus.Req0_Data  = 32'h11;
    bus.Req1_Valid = 1'b1;
    bus.Req1_Addr  = 2'd1;
    bus.Req1_Data  = 32'h22;
    settle();
    check("coll_rdy0", bus.Req0_Ready, 1'b0);
    check("coll_rdy1", bus.Req1_Ready, 1'b1);
    tick();
    bus.Req1_Valid = 1'b0;
    settle();
    check("coll_w1_gid",  bus.Grant_Id, 1'b1);
    check("coll_w1_addr", bus.In_Addr,  2'd1);
    check("coll_w1_data", bus.Data_in,  32'h22);
    check("coll_rdy0_b",  bus.Req0_Ready, 1'b1);
    tick();
    bus.Req0_Valid = 1'b0;
    settle();
    check("coll_rf1_mid", rf_model[1],  32'h22);
    check("coll_w2_gid",  bus.Grant_Id, 1'b0);
    check("coll_w2_data", bus.Data_in,  32'h11);
    tick();
    check("coll_rf1_final", rf_model[1], 32'h11);
    check("coll_rf0",       rf_model[0], 32'h55);

    // Hold-while-stalled: lone requester-1 write brings Prio back to 0 first
    bus.Req1_Valid = 1'b1;
    bus.Req1_Addr  = 2'd2;
    bus.Req1_Data  = 32'h77;
    tick();
    bus.Req0_Valid = 1'b1;
    bus.Req0_Addr  = 2'd0;
    bus.Req0_Data  = 32'h0A;
    bus.Req1_Addr  = 2'd3;
    bus.Req1_Data  = 32'hCAFE;
    settle();
    check("stall_rdy0", bus.Req0_Ready, 1'b1);
    check("stall_rdy1", bus.Req1_Ready, 1'b0);
    tick();
    bus.Req0_Valid = 1'b0;
    settle();
    check("stall_w0_gid",  bus.Grant_Id,   1'b0);
    check("stall_w0_data", bus.Data_in,    32'h0A);
    check("stall_rdy1_b",  bus.Req1_Ready, 1'b1);
    tick();
    bus.Req1_Valid = 1'b0;
    settle();
    check("stall_w1_gid",  bus.Grant_Id,  1'b1);
    check("stall_w1_addr", bus.In_Addr,   2'd3);
    check("stall_w1_data", bus.Data_in,   32'hCAFE);
    check("stall_cnt0",    bus.Wr_Count0, 8'd5);
    check("stall_cnt1",    bus.Wr_Count1, 8'd5);
    tick();

    // Lone requester 1 streams 300 writes from a fresh reset
    RST = 1'b1;
    tick();
    RST = 1'b0;
    for (int i = 0; i < 300; i++) begin
      bus.Req1_Valid = 1'b1;
      bus.Req1_Data  = 32'(i);
      bus.Req1_Addr  = 2'(i);
      settle();
      check("stream_rdy1", bus.Req1_Ready, 1'b1);
      check("stream_rdy0", bus.Req0_Ready, 1'b0);
      tick();
    end
    bus.Req1_Valid = 1'b0;
    settle();
    check("stream_cnt1", bus.Wr_Count1, 8'd44);
    check("stream_cnt0", bus.Wr_Count0, 8'd0);
    check("stream_data", bus.Data_in,   32'd299);
    check("stream_gid",  bus.Grant_Id,  1'b1);
    tick();

    // Reset mid-stream while a write is on WE and both requesters are valid
    bus.Req0_Valid = 1'b1;
    bus.Req0_Addr  = 2'd2;
    bus.Req0_Data  = 32'h1234;
    bus.Req1_Valid = 1'b1;
    bus.Req1_Addr  = 2'd1;
    bus.Req1_Data  = 32'h5678;
    settle();
    check("mid_rdy0", bus.Req0_Ready, 1'b1);
    tick();
    RST = 1'b1;
    settle();
    check("mid_rst_we",   bus.WE,         1'b1);
    check("mid_rst_rdy0", bus.Req0_Ready, 1'b0);
    check("mid_rst_rdy1", bus.Req1_Ready, 1'b0);
    tick();
    check("mid_commit",   rf_model[2],    32'h1234);
    check("mid_post_we",  bus.WE,         1'b0);
    check("mid_post_addr", bus.In_Addr,   2'd0);
    check("mid_post_data", bus.Data_in,   32'd0);
    check("mid_post_gid", bus.Grant_Id,   1'b0);
    check("mid_post_cnt0", bus.Wr_Count0, 8'd0);
    check("mid_post_cnt1", bus.Wr_Count1, 8'd0);
    RST = 1'b0;
    settle();
    check("mid_rel_rdy0", bus.Req0_Ready, 1'b1);
    check("mid_rel_rdy1", bus.Req1_Ready, 1'b0);
    tick();
    bus.Req0_Valid = 1'b0;
    bus.Req1_Valid = 1'b0;
    settle();
    check("mid_rel_gid",  bus.Grant_Id, 1'b0);
    check("mid_rel_data", bus.Data_in,  32'h1234);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
